// File: rtl/mc_seq_pkg.sv
// Shared definitions for the multicycle sequencer.
//   - Decoder path classes (PATH_*), as driven on mc_seq_ctrl.path.
//   - Sequencer state encoding (state_e).
//   - Bit positions of the one-hot stage display vector (STG_*).
//   - Helpers: is_hs_state() marks the enable/done handshake states, and
//     stage_of() maps a state to its stage LED pattern.
package mc_seq_pkg;

    localparam logic [3:0] PATH_MFX    = 4'd0;  // mfhi/mflo: write back only
    localparam logic [3:0] PATH_ALU    = 4'd1;  // ALU op with register write
    localparam logic [3:0] PATH_LOAD   = 4'd2;
    localparam logic [3:0] PATH_STORE  = 4'd3;
    localparam logic [3:0] PATH_BRANCH = 4'd4;
    localparam logic [3:0] PATH_J      = 4'd5;
    localparam logic [3:0] PATH_JAL    = 4'd6;
    localparam logic [3:0] PATH_NOWB   = 4'd7;  // executes, no write back
    localparam logic [3:0] PATH_JR     = 4'd8;
    localparam logic [3:0] PATH_HALT   = 4'd9;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FWAIT,
        ST_DECODE,
        ST_REGRD,
        ST_EXEC,
        ST_MEMACC,
        ST_MWAIT,
        ST_WBACK,
        ST_JUMP,
        ST_BRANCH,
        ST_HALT,
        ST_ERROR
    } state_e;

    localparam int STAGE_W = 9;
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_REG = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;
    localparam int STG_JU  = 6;
    localparam int STG_BR  = 7;
    localparam int STG_SK  = 8;

    function automatic logic is_hs_state(input state_e s);
        return (s == ST_DECODE) || (s == ST_REGRD) || (s == ST_EXEC) ||
               (s == ST_WBACK)  || (s == ST_JUMP)  || (s == ST_BRANCH);
    endfunction

    // Wait states share the LED of the state that issued the request.
    function automatic logic [STAGE_W-1:0] stage_of(input state_e s);
        logic [STAGE_W-1:0] v;
        v = '0;
        case (s)
            ST_FETCH, ST_FWAIT:  v[STG_IF]  = 1'b1;
            ST_DECODE:           v[STG_ID]  = 1'b1;
            ST_REGRD:            v[STG_REG] = 1'b1;
            ST_EXEC:             v[STG_EX]  = 1'b1;
            ST_MEMACC, ST_MWAIT: v[STG_MEM] = 1'b1;
            ST_WBACK:            v[STG_WB]  = 1'b1;
            ST_JUMP:             v[STG_JU]  = 1'b1;
            ST_BRANCH:           v[STG_BR]  = 1'b1;
            ST_HALT:             v[STG_SK]  = 1'b1;
            default:             v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mc_seq_hs.sv
// Enable/done tracker with watchdog, shared by all handshake states of the
// sequencer (only one sub-unit is ever active at a time).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   run        0 freezes enable and watchdog
//   start      state is being entered this edge: raise enable, clear watchdog
//   done       done strobe of the sub-unit owning the current state
//   en         registered enable of the active sub-unit
//   fire       done accepted this cycle (enable high and done high)
//   tmo        watchdog expires this cycle (2^TMO_W-1 cycles without done)
//
// Handshake: en rises on the edge that enters a state and stays high until the
// edge where done is sampled high; that edge clears en and the caller advances.
// done while en is low is ignored. When run=0 nothing advances, so a done
// pulse arriving while frozen is lost; units must hold done until en drops.
module mc_seq_hs #(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic start,
    input  logic done,
    output logic en,
    output logic fire,
    output logic tmo
);

    // The counter holds cycles already spent; the cycle on which it reads
    // 2^TMO_W-2 is the (2^TMO_W-1)th and last one allowed.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    logic             en_q, en_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    assign en   = en_q;
    assign fire = en_q & done;
    assign tmo  = en_q & ~done & (cnt_q == TMO_LAST);

    always_comb begin
        en_d  = en_q;
        cnt_d = cnt_q;
        if (run) begin
            // Entry wins over exit so back-to-back handshake states
            // (WBACK -> JUMP) start the next unit cleanly.
            if (start) begin
                en_d  = 1'b1;
                cnt_d = '0;
            end else if (fire || tmo) begin
                en_d  = 1'b0;
                cnt_d = '0;
            end else if (en_q) begin
                cnt_d = cnt_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            en_q  <= en_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multicycle sequencer for the MIPS core. Owns the PC and steps each
// instruction through fetch, decode, register read, execute, memory, write
// back, jump and branch according to the decoder path class.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 0 freezes state, PC and counters
//   path                decoder path class (mc_seq_pkg::PATH_*)
//   *_done / *_en       sub-unit handshakes (dec, reg, alu, br, ju)
//   alu_addr            load/store address
//   pc_next_b/pc_next_j branch / jump targets
//   dbg_req, dbg_addr   debug memory read, served only while halted
//   reg_write           register-file write qualifier (write back)
//   mem_en/ren/wen/addr memory controls
//   ir_load             pulse: memory data is the instruction word
//   pc                  program counter
//   stage               one-hot {SK,BR,JU,WB,MEM,EX,REG,ID,IF}
//   halted, err         in HALT / in ERROR (ERROR sticky until rst)
//   dbg_state           raw sequencer state for debug visibility
//   cyc_cnt, instr_cnt  performance counters, only with MC_SEQ_PERF_EN
// Build option: define MC_SEQ_PERF_EN to add the performance counters.
module mc_seq_ctrl
    import mc_seq_pkg::*;
#(
    parameter int          PC_W     = 32,
    parameter int          ADDR_W   = 16,
    parameter int          PC_INC   = 1,
    parameter int unsigned RESET_PC = 0,
    parameter int          MEM_LAT  = 3,
    parameter int          TMO_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [3:0]        path,
    input  logic              dec_done,
    input  logic              reg_done,
    input  logic              alu_done,
    input  logic              br_done,
    input  logic              ju_done,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [PC_W-1:0]   pc_next_b,
    input  logic [PC_W-1:0]   pc_next_j,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dec_en,
    output logic              reg_en,
    output logic              alu_en,
    output logic              br_en,
    output logic              ju_en,
    output logic              reg_write,
    output logic              mem_en,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              ir_load,
    output logic [PC_W-1:0]   pc,
    output logic [8:0]        stage,
    output logic              halted,
    output logic [3:0]        dbg_state,
`ifdef MC_SEQ_PERF_EN
    output logic [31:0]       cyc_cnt,
    output logic [31:0]       instr_cnt,
`endif
    output logic              err
);

    localparam int               LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [3:0]        path_q, path_d;

    logic hs_done, hs_start, hs_en, hs_fire, hs_tmo;

    // Only the unit owning the current state can complete it.
    always_comb begin
        hs_done = 1'b0;
        case (state_q)
            ST_DECODE:          hs_done = dec_done;
            ST_REGRD, ST_WBACK: hs_done = reg_done;
            ST_EXEC:            hs_done = alu_done;
            ST_JUMP:            hs_done = ju_done;
            ST_BRANCH:          hs_done = br_done;
            default:            hs_done = 1'b0;
        endcase
    end

    assign hs_start = is_hs_state(state_d) && (state_d != state_q);

    mc_seq_hs #(
        .TMO_W (TMO_W)
    ) u_hs (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .start (hs_start),
        .done  (hs_done),
        .en    (hs_en),
        .fire  (hs_fire),
        .tmo   (hs_tmo)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lat_d   = lat_q;
        path_d  = path_q;
        if (run) begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    lat_d   = '0;
                    state_d = ST_FWAIT;
                end
                ST_FWAIT: begin
                    if (lat_q == LAT_LAST) state_d = ST_DECODE;
                    else                   lat_d   = lat_q + LAT_W'(1);
                end
                ST_DECODE: begin
                    if (hs_tmo) begin
                        state_d = ST_ERROR;
                    end else if (hs_fire) begin
                        pc_d   = pc_q + PC_W'(PC_INC);
                        // The class is kept for the later branch points.
                        path_d = path;
                        case (path)
                            PATH_MFX, PATH_JAL: state_d = ST_WBACK;
                            PATH_J:             state_d = ST_JUMP;
                            PATH_HALT:          state_d = ST_HALT;
                            PATH_ALU, PATH_LOAD, PATH_STORE,
                            PATH_BRANCH, PATH_NOWB, PATH_JR:
                                                state_d = ST_REGRD;
                            default:            state_d = ST_ERROR;
                        endcase
                    end
                end
                ST_REGRD: begin
                    if (hs_tmo)       state_d = ST_ERROR;
                    else if (hs_fire) state_d = (path_q == PATH_JR) ? ST_JUMP : ST_EXEC;
                end
                ST_EXEC: begin
                    if (hs_tmo) begin
                        state_d = ST_ERROR;
                    end else if (hs_fire) begin
                        case (path_q)
                            PATH_ALU:               state_d = ST_WBACK;
                            PATH_LOAD, PATH_STORE:  state_d = ST_MEMACC;
                            PATH_BRANCH:            state_d = ST_BRANCH;
                            default:                state_d = ST_FETCH;
                        endcase
                    end
                end
                ST_MEMACC: begin
                    lat_d   = '0;
                    state_d = (path_q == PATH_LOAD) ? ST_MWAIT : ST_FETCH;
                end
                ST_MWAIT: begin
                    if (lat_q == LAT_LAST) state_d = ST_WBACK;
                    else                   lat_d   = lat_q + LAT_W'(1);
                end
                ST_WBACK: begin
                    if (hs_tmo)       state_d = ST_ERROR;
                    else if (hs_fire) state_d = (path_q == PATH_JAL) ? ST_JUMP : ST_FETCH;
                end
                ST_JUMP: begin
                    if (hs_tmo) begin
                        state_d = ST_ERROR;
                    end else if (hs_fire) begin
                        pc_d    = pc_next_j;
                        state_d = ST_FETCH;
                    end
                end
                ST_BRANCH: begin
                    if (hs_tmo) begin
                        state_d = ST_ERROR;
                    end else if (hs_fire) begin
                        pc_d    = pc_next_b;
                        state_d = ST_FETCH;
                    end
                end
                ST_HALT, ST_ERROR: state_d = state_q;
                default:           state_d = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= PC_W'(RESET_PC);
            lat_q   <= '0;
            path_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lat_q   <= lat_d;
            path_q  <= path_d;
        end
    end

    always_comb begin
        dec_en    = hs_en && (state_q == ST_DECODE);
        reg_en    = hs_en && ((state_q == ST_REGRD) || (state_q == ST_WBACK));
        alu_en    = hs_en && (state_q == ST_EXEC);
        br_en     = hs_en && (state_q == ST_BRANCH);
        ju_en     = hs_en && (state_q == ST_JUMP);
        reg_write = hs_en && (state_q == ST_WBACK);
        mem_en    = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        ir_load   = 1'b0;
        case (state_q)
            // The fetch read stays asserted through the wait so the address
            // is stable until the word is captured.
            ST_FETCH, ST_FWAIT: begin
                mem_en   = 1'b1;
                mem_ren  = 1'b1;
                mem_addr = pc_q[ADDR_W-1:0];
                ir_load  = (state_q == ST_FWAIT) && (lat_q == LAT_LAST);
            end
            ST_MEMACC: begin
                mem_en   = 1'b1;
                mem_addr = alu_addr;
                mem_ren  = (path_q == PATH_LOAD);
                mem_wen  = (path_q != PATH_LOAD);
            end
            ST_HALT: begin
                if (dbg_req) begin
                    mem_en   = 1'b1;
                    mem_ren  = 1'b1;
                    mem_addr = dbg_addr;
                end
            end
            default: ;
        endcase
    end

    assign pc        = pc_q;
    assign stage     = stage_of(state_q);
    assign halted    = (state_q == ST_HALT);
    assign err       = (state_q == ST_ERROR);
    assign dbg_state = state_q;

`ifdef MC_SEQ_PERF_EN
    logic [31:0] cyc_q, cyc_d, instr_q, instr_d;

    always_comb begin
        cyc_d   = cyc_q;
        instr_d = instr_q;
        if (run && (state_q != ST_HALT) && (state_q != ST_ERROR)) cyc_d = cyc_q + 32'd1;
        if (run && (state_q == ST_DECODE) && hs_fire)             instr_d = instr_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            instr_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            instr_q <= instr_d;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Bench for mc_seq_ctrl: directed and random instructions checked cycle by
// cycle against an expected stage/control trace derived from the instruction
// class, with a sub-unit responder that answers each enable after a chosen
// number of cycles.
module tb_mc_seq_ctrl;

    localparam int MEM_LAT = 3;
    localparam int TMO_W   = 4;
    localparam int TMO_CYC = (1 << TMO_W) - 1;

    // Stage LED positions, {SK,BR,JU,WB,MEM,EX,REG,ID,IF}; -1 means none.
    localparam int S_IF = 0, S_ID = 1, S_REG = 2, S_EX = 3, S_MEM = 4;
    localparam int S_WB = 5, S_JU = 6, S_BR = 7, S_SK = 8, S_NONE = -1;

    // Expected control bits per cycle.
    localparam logic [5:0] C_IR  = 6'b000001;
    localparam logic [5:0] C_WB  = 6'b000010;
    localparam logic [5:0] C_REN = 6'b000100;
    localparam logic [5:0] C_WEN = 6'b001000;
    localparam logic [5:0] C_ADR = 6'b010000;
    localparam logic [5:0] C_ERR = 6'b100000;

    logic        clk, rst, run;
    logic [3:0]  path;
    logic        dec_done = 1'b0, reg_done = 1'b0, alu_done = 1'b0;
    logic        br_done = 1'b0, ju_done = 1'b0;
    logic [15:0] alu_addr, dbg_addr;
    logic [31:0] pc_next_b, pc_next_j;
    logic        dbg_req;
    logic        dec_en, reg_en, alu_en, br_en, ju_en, reg_write;
    logic        mem_en, mem_ren, mem_wen, ir_load, halted, err;
    logic [15:0] mem_addr;
    logic [31:0] pc;
    logic [8:0]  stage;
    logic [3:0]  dbg_state;
`ifdef MC_SEQ_PERF_EN
    logic [31:0] cyc_cnt, instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0]  exp_q[$];
    logic [5:0]  exp_ctl_q[$];
    logic [15:0] exp_addr_q[$];
    logic [31:0] pc_exp;

    int resp_lat  = 0;
    bit alu_stall = 0;
    int dec_age = 0, reg_age = 0, alu_age = 0, br_age = 0, ju_age = 0;

    mc_seq_ctrl #(
        .PC_W     (32),
        .ADDR_W   (16),
        .PC_INC   (1),
        .RESET_PC (0),
        .MEM_LAT  (MEM_LAT),
        .TMO_W    (TMO_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .path      (path),
        .dec_done  (dec_done),
        .reg_done  (reg_done),
        .alu_done  (alu_done),
        .br_done   (br_done),
        .ju_done   (ju_done),
        .alu_addr  (alu_addr),
        .pc_next_b (pc_next_b),
        .pc_next_j (pc_next_j),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dec_en    (dec_en),
        .reg_en    (reg_en),
        .alu_en    (alu_en),
        .br_en     (br_en),
        .ju_en     (ju_en),
        .reg_write (reg_write),
        .mem_en    (mem_en),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .ir_load   (ir_load),
        .pc        (pc),
        .stage     (stage),
        .halted    (halted),
        .dbg_state (dbg_state),
`ifdef MC_SEQ_PERF_EN
        .cyc_cnt   (cyc_cnt),
        .instr_cnt (instr_cnt),
`endif
        .err       (err)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sub-unit responder: each unit raises done in the (resp_lat+1)th cycle
    // its enable is high and holds it until the enable drops.
    always @(negedge clk) begin
        dec_age = dec_en ? dec_age + 1 : 0;
        reg_age = reg_en ? reg_age + 1 : 0;
        alu_age = alu_en ? alu_age + 1 : 0;
        br_age  = br_en  ? br_age + 1  : 0;
        ju_age  = ju_en  ? ju_age + 1  : 0;
        dec_done = dec_en && (dec_age > resp_lat);
        reg_done = reg_en && (reg_age > resp_lat);
        alu_done = alu_en && (alu_age > resp_lat) && !alu_stall;
        br_done  = br_en  && (br_age > resp_lat);
        ju_done  = ju_en  && (ju_age > resp_lat);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected trace of one instruction
    task automatic push(input int sbit, input logic [5:0] ctl, input logic [15:0] a);
        logic [8:0] s;
        s = '0;
        if (sbit >= 0) s[sbit] = 1'b1;
        exp_q.push_back(s);
        exp_ctl_q.push_back(ctl);
        exp_addr_q.push_back(a);
    endtask

    task automatic push_hs(input int sbit, input int lat);
        for (int i = 0; i <= lat; i++)
            push(sbit, (sbit == S_WB) ? C_WB : 6'b0, 16'h0);
    endtask

    // Register read and execute; returns 0 when the watchdog ends the trace.
    task automatic push_rx(input int lat, input bit stall, output bit ok);
        push_hs(S_REG, lat);
        if (stall) begin
            for (int i = 0; i < TMO_CYC; i++) push(S_EX, 6'b0, 16'h0);
            push(S_NONE, C_ERR, 16'h0);
            ok = 1'b0;
        end else begin
            push_hs(S_EX, lat);
            ok = 1'b1;
        end
    endtask

    task automatic build_trace(input int p, input int lat, input bit stall,
                               input logic [15:0] aa, input logic [31:0] tj,
                               input logic [31:0] tbr);
        bit ok;
        logic [31:0] pc_after;
        exp_q.delete();
        exp_ctl_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i <= MEM_LAT; i++)
            push(S_IF, C_REN | C_ADR | ((i == MEM_LAT) ? C_IR : 6'b0), pc_exp[15:0]);
        push_hs(S_ID, lat);
        pc_after = pc_exp + 32'd1;
        case (p)
            0: push_hs(S_WB, lat);
            1: begin push_rx(lat, stall, ok); if (ok) push_hs(S_WB, lat); end
            2: begin
                push_rx(lat, stall, ok);
                if (ok) begin
                    push(S_MEM, C_REN | C_ADR, aa);
                    for (int i = 0; i < MEM_LAT; i++) push(S_MEM, 6'b0, 16'h0);
                    push_hs(S_WB, lat);
                end
            end
            3: begin push_rx(lat, stall, ok); if (ok) push(S_MEM, C_WEN | C_ADR, aa); end
            4: begin push_rx(lat, stall, ok); if (ok) push_hs(S_BR, lat); pc_after = tbr; end
            5: begin push_hs(S_JU, lat); pc_after = tj; end
            6: begin push_hs(S_WB, lat); push_hs(S_JU, lat); pc_after = tj; end
            7: push_rx(lat, stall, ok);
            8: begin push_hs(S_REG, lat); push_hs(S_JU, lat); pc_after = tj; end
            9: push(S_SK, 6'b0, 16'h0);
            default: push(S_NONE, C_ERR, 16'h0);
        endcase
        pc_exp = pc_after;
    endtask

    task automatic check_cycle(input string tag, input int i);
        logic [8:0] s;
        logic [5:0] c;
        s = exp_q[i];
        c = exp_ctl_q[i];
        check($sformatf("%s[%0d].stage", tag, i), stage, s);
        check($sformatf("%s[%0d].ctl", tag, i),
              {err, mem_wen, mem_ren, reg_write, ir_load},
              {c[5], c[3], c[2], c[1], c[0]});
        check($sformatf("%s[%0d].mem_en", tag, i), mem_en, c[2] | c[3]);
        check($sformatf("%s[%0d].enables", tag, i),
              {dec_en, reg_en, alu_en, br_en, ju_en},
              {s[S_ID], s[S_REG] | s[S_WB], s[S_EX], s[S_BR], s[S_JU]});
        check($sformatf("%s[%0d].halted", tag, i), halted, s[S_SK]);
        if (c[4]) check($sformatf("%s[%0d].mem_addr", tag, i), mem_addr, exp_addr_q[i]);
    endtask

    // Driver: called in a FETCH cycle; checks n trace cycles (all when n < 0).
    task automatic do_instr(input string tag, input int p, input int lat,
                            input logic [15:0] aa, input logic [31:0] tj,
                            input logic [31:0] tbr, input bit stall, input int n);
        int lim;
        path      = 4'(p);
        resp_lat  = lat;
        alu_stall = stall;
        alu_addr  = aa;
        pc_next_j = tj;
        pc_next_b = tbr;
        check({tag, ".pc_at_fetch"}, pc, pc_exp);
        build_trace(p, lat, stall, aa, tj, tbr);
        lim = (n < 0) ? exp_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            check_cycle(tag, i);
            step();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".pc"}, pc, 32'h0);
        check({tag, ".stage"}, stage, 9'h0);
        check({tag, ".outs"},
              {dec_en, reg_en, alu_en, br_en, ju_en, reg_write, mem_en,
               mem_ren, mem_wen, ir_load, halted, err, mem_addr}, 28'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        check_reset(tag);
        rst = 1'b0;
        alu_stall = 1'b0;
        run = 1'b1;
        step();
        pc_exp = 32'h0;
    endtask

    initial begin
        rst = 1'b1;  run = 1'b0;  path = 4'd0;  alu_addr = '0;
        pc_next_b = '0;  pc_next_j = '0;  dbg_req = 1'b0;  dbg_addr = '0;
        pc_exp = 32'h0;
        step();
        step();
        check_reset("reset");
        rst = 1'b0;
        run = 1'b1;
        step();

        // Directed instructions
        do_instr("alu_l0", 1, 0, 16'h0000, 32'h0, 32'h0, 1'b0, -1);
        do_instr("load_40", 2, 1, 16'h0040, 32'h0, 32'h0, 1'b0, -1);
        do_instr("branch_20", 4, 0, 16'h0000, 32'h0, 32'h20, 1'b0, -1);
        do_instr("jal", 6, 1, 16'h0000, 32'h0000_1234, 32'h0, 1'b0, -1);
        do_instr("store", 3, 2, 16'hbeef, 32'h0, 32'h0, 1'b0, -1);
        do_instr("jr_wrap", 8, 0, 16'h0, 32'hffff_ffff, 32'h0, 1'b0, -1);

        // Random instructions
        for (int k = 0; k < 24; k++)
            do_instr($sformatf("rnd%0d", k), $urandom_range(0, 8), $urandom_range(0, 2),
                     16'($urandom), $urandom, $urandom, 1'b0, -1);

        // Halt and debug read
        do_instr("halt", 9, 1, 16'h0, 32'h0, 32'h0, 1'b0, -1);
        check("halt.pc", pc, pc_exp);
        check("halt.sticky", {halted, stage}, {1'b1, 9'h100});
        dbg_addr = 16'h0003;
        dbg_req  = 1'b1;
        #1;
        check("dbg.read", {mem_en, mem_ren, mem_wen, mem_addr}, {3'b110, 16'h0003});
        dbg_req = 1'b0;
        #1;
        check("dbg.idle", {mem_en, mem_ren, mem_addr}, 18'h0);
        do_reset("halt_rst");

        // Illegal path class
        do_instr("bad_path", 12, 0, 16'h0, 32'h0, 32'h0, 1'b0, -1);
        step();
        step();
        check("err.sticky", {err, stage, dec_en, reg_en, alu_en, br_en, ju_en}, {1'b1, 14'h0});
        do_reset("err_rst");

        // Watchdog on a stalled ALU
        do_instr("wdog", 1, 0, 16'h0, 32'h0, 32'h0, 1'b1, -1);
        step();
        check("wdog.sticky", {err, alu_en}, 2'b10);
        do_reset("wdog_rst");

        // Reset in the middle of the load data wait
        do_instr("mwait", 2, 0, 16'h0040, 32'h0, 32'h0, 1'b0, MEM_LAT + 6);
        check("mwait.stage", stage, 9'h010);
        do_reset("mwait_rst");

        // Freeze during execute; done raised while frozen is held by the unit
        do_instr("freeze", 1, 2, 16'h0, 32'h0, 32'h0, 1'b0, MEM_LAT + 8);
        run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("freeze%0d.stage", k), stage, 9'h008);
            check($sformatf("freeze%0d.pc", k), pc, pc_exp);
            check($sformatf("freeze%0d.alu_en", k), alu_en, 1'b1);
        end
        run = 1'b1;
        step();
        check("unfreeze.stage", stage, 9'h020);
        check("unfreeze.reg_write", reg_write, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
